// File: rtl/led_sum_ctrl.sv
// -----------------------------------------------------------------------------
// led_sum_ctrl
//   Two-operand adder feeding an LED bank. A load in IDLE captures the operands
//   and the mode. The following edge writes the result to led and pulses done,
//   then the block returns to IDLE. In SUM mode, led = s1 + s2. In ACC mode,
//   led = led + s1 + s2, which can overflow. On overflow led either saturates
//   or wraps, and ovf is stretched for OVF_HOLD cycles.
//
// Parameters
//   W        operand width (>= 2); led is W+1 bits
//   SAT      1 = saturate on ACC overflow, 0 = wrap modulo 2^(W+1)
//   OVF_HOLD cycles ovf stays high after an overflow (>= 1)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous reset, active low
//   s1,s2  in   W-bit unsigned operands
//   load   in   operation request, taken only while ready = 1
//   mode   in   0 = SUM, 1 = ACC
//   clear  in   synchronous clear of led, ovf stretch and any pending operation
//   ready  out  high in IDLE
//   led    out  registered W+1 bit result
//   done   out  one-cycle pulse with every led update
//   ovf    out  stretched overflow flag (registered)
// -----------------------------------------------------------------------------
module led_sum_ctrl #(
  parameter int W        = 4,
  parameter int SAT      = 1,
  parameter int OVF_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] s1,
  input  logic [W-1:0] s2,
  input  logic         load,
  input  logic         mode,
  input  logic         clear,
  output logic         ready,
  output logic [W:0]   led,
  output logic         done,
  output logic         ovf
);

  localparam int CW = $clog2(OVF_HOLD + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_mode;
  logic [W:0]     r_led;
  logic           r_done;
  logic           r_ovf;
  logic [CW-1:0]  r_cnt;

  logic           w_accept;
  logic [W+1:0]   w_base;
  logic [W+1:0]   w_sum;
  logic           w_over;
  logic [W:0]     w_result;
  logic [CW-1:0]  w_cnt_next;

  // Load is only taken from IDLE, and a simultaneous clear wins.
  assign w_accept = (r_state == IDLE) && load && !clear;

  // One extra bit of headroom: the largest ACC sum (2^(W+1)-1 + 2*(2^W-1))
  // still fits in W+2 bits, so the top bit alone flags overflow.
  assign w_base = r_mode ? {1'b0, r_led} : '0;
  assign w_sum  = w_base + {2'b00, r_a} + {2'b00, r_b};
  assign w_over = r_mode && w_sum[W+1];

  // The wrap case is simply the low W+1 bits of the sum.
  assign w_result = (w_over && (SAT != 0)) ? '1 : w_sum[W:0];

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = CALC;
      CALC:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (clear) w_state_next = IDLE;
  end

  // Overflow reloads (retriggers) the stretch counter; otherwise it counts
  // down and parks at zero.
  always_comb begin
    w_cnt_next = r_cnt;
    if (clear) begin
      w_cnt_next = '0;
    end else if ((r_state == CALC) && w_over) begin
      w_cnt_next = CW'(OVF_HOLD);
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_led   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // ovf is registered from the next counter value so that it rises on
      // the same edge as led, with no combinational path to the output.
      r_ovf   <= (w_cnt_next != '0);
      r_done  <= (r_state == CALC) && !clear;
      if (w_accept) begin
        r_a    <= s1;
        r_b    <= s2;
        r_mode <= mode;
      end
      if (clear) begin
        r_led <= '0;
      end else if (r_state == CALC) begin
        r_led <= w_result;
      end
    end
  end

  assign ready = (r_state == IDLE);
  assign led   = r_led;
  assign done  = r_done;
  assign ovf   = r_ovf;

endmodule
